// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared encodings and constants for the shift-add multiplier
//
// Purpose: operation codes, FSM state encoding and iteration count shared by
// mul_unit and its bench-facing users.
// Ports: none (package).
package mul_pkg;

  // Operation select on MulOp. 2'b01 is not listed and decodes as MUL.
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b10,
    OP_SMULL = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // One multiplier bit is consumed per RUN cycle.
  localparam int ITER = 32;

  // Counter value seen on the last RUN cycle.
  localparam logic [4:0] ITER_LAST = 5'(ITER - 1);

endpackage

// File: rtl/cond_neg64.sv
// rtl/cond_neg64.sv - 64-bit conditional two's-complement negator
//
// Purpose: dout = neg ? -din : din, purely combinational.
// Ports:
//   neg  - in,  1  : negate when high
//   din  - in,  64 : value
//   dout - out, 64 : optionally negated value
module cond_neg64 (
  input  logic        neg,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  // Invert-and-increment form; the +neg folds the increment into one adder.
  always_comb begin
    dout = (din ^ {64{neg}}) + {63'b0, neg};
  end

endmodule

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - radix-2 shift-add 32x32 multiplier with fixed latency
//
// Purpose: multi-cycle MUL / UMULL / SMULL. Operands are captured on the
// accepting edge, 32 RUN cycles accumulate one multiplier bit each, one FIX
// cycle applies the sign, and DONE presents the registered 64-bit product.
// Ports:
//   clk      - in,  1  : system clock, rising edge
//   reset    - in,  1  : synchronous active-high reset
//   Start    - in,  1  : begin a multiply (only honoured in IDLE or DONE)
//   MulOp    - in,  2  : 00 MUL, 10 UMULL, 11 SMULL, 01 as MUL
//   SrcA     - in,  32 : multiplicand
//   SrcB     - in,  32 : multiplier
//   longFlag - in,  1  : selects ResHi onto Result
//   Busy     - out, 1  : high in RUN and FIX
//   Done     - out, 1  : one-cycle result-valid pulse (DONE state)
//   Result   - out, 32 : longFlag ? ResHi : ResLo (combinational)
//   ResHi    - out, 32 : registered high product word
//   ResLo    - out, 32 : registered low product word
module mul_unit
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MulOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        longFlag,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [31:0] ResHi,
  output logic [31:0] ResLo
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic        sign_q, sign_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  logic        is_smull;
  logic        accept;
  logic [63:0] ext_a, ext_b;
  logic [63:0] mag_a, mag_b;
  logic [63:0] acc_fixed;

  assign is_smull = (MulOp == OP_SMULL);
  assign accept   = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // For SMULL the operands are sign-extended before negation, so the
  // magnitude lands in the low 32 bits with zeros above. 0x80000000 becomes
  // 0x0000_0000_8000_0000, i.e. 2^31 taken as unsigned.
  assign ext_a = is_smull ? {{32{SrcA[31]}}, SrcA} : {32'b0, SrcA};
  assign ext_b = is_smull ? {{32{SrcB[31]}}, SrcB} : {32'b0, SrcB};

  cond_neg64 u_neg_a (
    .neg  (is_smull & SrcA[31]),
    .din  (ext_a),
    .dout (mag_a)
  );

  cond_neg64 u_neg_b (
    .neg  (is_smull & SrcB[31]),
    .din  (ext_b),
    .dout (mag_b)
  );

  // Sign correction of the unsigned magnitude product in the FIX cycle.
  cond_neg64 u_neg_fix (
    .neg  (sign_q),
    .din  (acc_q),
    .dout (acc_fixed)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_RUN;
          cnt_d    = 5'd0;
          acc_d    = 64'd0;
          mcand_d  = mag_a;
          mplier_d = mag_b;
          sign_d   = is_smull & (SrcA[31] ^ SrcB[31]);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Multiplicand shifts up and multiplier shifts down each cycle, so
        // only bit 0 of the multiplier is ever examined (LSB first).
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[63:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) begin
          state_d = ST_FIX;
          cnt_d   = 5'd0;
        end
      end

      ST_FIX: begin
        state_d  = ST_DONE;
        acc_d    = acc_fixed;
        res_hi_d = acc_fixed[63:32];
        res_lo_d = acc_fixed[31:0];
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 64'd0;
      sign_q   <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Status decodes from the state register only, so Start never reaches
  // Busy or Done combinationally.
  assign Busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign Done   = (state_q == ST_DONE);
  assign ResHi  = res_hi_q;
  assign ResLo  = res_lo_q;
  assign Result = longFlag ? res_hi_q : res_lo_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - scoreboard bench for mul_unit
module tb_mul_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MulOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        longFlag;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic [31:0] ResHi;
  logic [31:0] ResLo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  mul_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MulOp    (MulOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .longFlag (longFlag),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .ResHi    (ResHi),
    .ResLo    (ResLo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drives the request during the current cycle (cycle 0); the DUT accepts on
  // the next edge and must show Done in cycle 0+34.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    MulOp = op;
    SrcA  = a;
    SrcB  = b;
    Start = 1'b1;
    e.hi  = hi;
    e.lo  = lo;
    e.cyc = cyc + 34;
    exp_q.push_back(e);
    @(posedge clk); #1;
    Start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
    MulOp = 2'($urandom_range(0, 3));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    start_op(op, a, b, hi, lo);
    chk("busy_in_run", Busy, 1'b1);
    repeat (34) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per Done cycle.
  initial begin
    exp_t e;
    longFlag = 1'b0;
    forever begin
      @(negedge clk);
      if (Done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done at cycle %0d: got Done=1 expected no pending result", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("res_hi", ResHi, e.hi);
          chk("res_lo", ResLo, e.lo);
          chk("busy_in_done", Busy, 1'b0);
          longFlag = 1'b0;
          #1;
          chk("result_lo_sel", Result, e.lo);
          longFlag = 1'b1;
          #1;
          chk("result_hi_sel", Result, e.hi);
          longFlag = 1'b0;
        end
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    Start = 1'b1;
    MulOp = 2'b00;
    SrcA  = 32'd3;
    SrcB  = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    // Start asserted together with reset must not launch anything.
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_reshi", ResHi, 32'd0);
    chk("reset_reslo", ResLo, 32'd0);
    chk("reset_result", Result, 32'd0);
    Start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", Busy, 1'b0);

    run_op(2'b00, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(2'b11, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    run_op(2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    run_op(2'b10, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000);

    // Start pulses with different operands at +5 and +20 must be ignored.
    start_op(2'b10, 32'h0000_1234, 32'h0000_0100, 32'h0000_0000, 32'h0012_3400);
    repeat (4) @(posedge clk);
    #1;
    Start = 1'b1; MulOp = 2'b11; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0BAD_F00D;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    Start = 1'b1; MulOp = 2'b00; SrcA = 32'h0000_0009; SrcB = 32'h0000_0009;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("busy_after_ignored_start", Busy, 1'b1);
    repeat (14) @(posedge clk);
    #1;

    // Reset mid-run aborts: status and results clear, no Done follows.
    MulOp = 2'b00; SrcA = 32'd5; SrcB = 32'd5; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_reshi", ResHi, 32'd0);
    chk("abort_reslo", ResLo, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Start held through DONE: second op launches with no IDLE gap.
    begin
      exp_t e2;
      t = cyc;
      start_op(2'b10, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001);
      Start = 1'b1;
      MulOp = 2'b11;
      SrcA  = 32'hFFFF_FFFE;
      SrcB  = 32'h0000_0007;
      e2.hi  = 32'hFFFF_FFFF;
      e2.lo  = 32'hFFFF_FFF2;
      e2.cyc = t + 68;
      exp_q.push_back(e2);
      for (int k = 1; k <= 68; k++) begin
        chk($sformatf("b2b_busy_k%0d", k), Busy, (k != 34 && k != 68) ? 1'b1 : 1'b0);
        if (k == 35) Start = 1'b0;
        @(posedge clk); #1;
      end
      chk("b2b_idle_after", Busy, 1'b0);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL missing_done: got %0d results outstanding expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1, request to begin a multiply; sampled only when accepting.
REQ-004 SHALL have port MulOp, input, 2, operation: 00 MUL (32-bit), 10 UMULL, 11 SMULL; 01 treated as MUL.
REQ-005 SHALL have port SrcA, input, 32, multiplicand.
REQ-006 SHALL have port SrcB, input, 32, multiplier.
REQ-007 SHALL have port longFlag, input, 1, from the control FSM; selects the high product word onto Result.
REQ-008 SHALL have port Busy, output, 1, high while a multiply is in progress.
REQ-009 SHALL have port Done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port Result, output, 32, longFlag ? ResHi : ResLo, combinational select.
REQ-011 SHALL have ports ResHi and ResLo, output, 32 each, registered 64-bit product halves.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX, DONE.
- IDLE -> RUN on Start.
- RUN -> FIX after 32 iterations.
- FIX -> DONE unconditionally.
- DONE -> RUN on Start, else IDLE.
REQ-013 SHALL accept Start only in IDLE or DONE; Start in RUN/FIX is ignored, with no effect on operands or count.
REQ-014 SHALL latch SrcA, SrcB, MulOp on the accepting edge; later input changes have no effect on the product.
REQ-015 SHALL, for SMULL, latch operand magnitudes and record sign = SrcA[31] XOR SrcB[31]; for MUL/UMULL the operands are taken unsigned with sign = 0.
REQ-016 SHALL perform radix-2 shift-add: one multiplier bit per RUN cycle, LSB first, 5-bit iteration counter 0..31, 64-bit accumulator.
REQ-017 SHALL, in FIX, two's-complement negate the 64-bit accumulator when sign = 1, else leave it unchanged; FIX is always one cycle, so latency is fixed.
REQ-018 SHALL update ResHi/ResLo only on the FIX->DONE edge and hold them until the next FIX->DONE edge.
REQ-019 SHALL, for MUL, produce ResLo = low 32 bits of the product; ResHi is still the full unsigned high word.
REQ-020 SHALL assert Done only in DONE: exactly 34 cycles after the accepting edge, for one cycle.
REQ-021 SHALL assert Busy in RUN and FIX and deassert it in IDLE and DONE.
REQ-022 SHALL support back-to-back operations: Start in DONE launches a new multiply with no IDLE gap.
REQ-023 SHALL handle the SMULL magnitude of 0x80000000 as 2^31, i.e. unsigned 33-bit-safe, giving the correct product.

Reset
REQ-024 SHALL, when reset = 1 at a clock edge, force IDLE, Busy = 0, Done = 0, ResHi = ResLo = 0, counter = 0, and clear the accumulator and latched operands.
REQ-025 SHALL let reset take priority over a simultaneous Start.
REQ-026 SHALL, on reset during RUN/FIX, abort the operation: no Done pulse and no result update.

Structure
REQ-027 SHALL place the MulOp encodings (MUL, UMULL, SMULL), the state encoding and the ITER = 32 constant in shared package mul_pkg.
REQ-028 SHALL use one sub-module, cond_neg64, a 64-bit conditional two's-complement negator, reused for the FIX step; operand magnitudes use its low 32 bits.
REQ-029 SHALL contain no combinational path from Start to Busy or Done.

Verification
REQ-030 MUL 7 x 6 -> Done at +34 cycles, ResLo = 0x0000002A, Result (longFlag = 0) = 0x0000002A.
REQ-031 UMULL 0xFFFFFFFF x 0xFFFFFFFF -> ResHi = 0xFFFFFFFE, ResLo = 0x00000001; Result follows longFlag toggle in the same cycle.
REQ-032 SMULL 0xFFFFFFFF x 0x00000002 -> ResHi = 0xFFFFFFFF, ResLo = 0xFFFFFFFE; SMULL 0x80000000 x 0x80000000 -> ResHi = 0x40000000, ResLo = 0.
REQ-033 Start pulses and operand changes at cycles +5 and +20 of a run -> ignored; original result delivered at +34, with a single Done pulse.
REQ-034 Reset at cycle +10 of a run -> next cycle Busy = 0, ResHi = ResLo = 0; no Done pulse within 40 cycles.
REQ-035 Start held high across DONE -> second multiply accepted there, second Done exactly 34 cycles later, Busy low only during the DONE cycle.
